// File: rtl/clipq_bram_pkg.sv
// ---------------------------------------------------------------------------
// clipq_bram_pkg
// Shared definitions for the accelerator scratch BRAM and the logic that
// talks to it: bus widths, write-request encodings, default depth, the
// per-cycle access classification and the word-range helper.
// ---------------------------------------------------------------------------
package clipq_bram_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BRAM_DEPTH = 60001;

    localparam logic [3:0] WREQ_FULL = 4'b1111;
    localparam logic [3:0] WREQ_NONE = 4'b0000;

    // What the granted requester (if any) does to the BRAM this cycle.
    typedef enum logic [1:0] {
        ACC_IDLE   = 2'd0,  // nobody granted
        ACC_READ   = 2'd1,  // in-range read, BRAM enabled
        ACC_WRITE  = 2'd2,  // in-range full-word write, BRAM enabled
        ACC_REJECT = 2'd3   // accepted but out of range, BRAM untouched
    } acc_kind_e;

    // True when the word index lies inside a BRAM of 'depth' words.
    // The index is the byte address with its two low bits already dropped.
    function automatic logic word_in_range(input logic [ADDR_W-3:0] word_idx,
                                           input int                depth);
        logic [ADDR_W-1:0] limit;
        limit = ADDR_W'(depth);
        return {2'b00, word_idx} < limit;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// N-way round-robin priority selector. The requester just after 'ptr' has
// the highest priority, then ptr+2, ... wrapping modulo N.
//
// Ports:
//   req   in  [N-1:0]   request vector
//   ptr   in  [PW-1:0]  index of the most recently served requester
//   grant out [N-1:0]   one-hot grant, or zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    localparam logic [PW:0] N_W = (PW+1)'(N);

    logic [PW:0] idx;
    logic        found;

    // Walk the N candidates in priority order; ptr+k is below 2N, so a
    // single conditional subtraction performs the modulo.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (!found && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
// Shares the single-port scratch BRAM (one 32-bit access per clock, 1-cycle
// registered read) between NUM_REQ requesters with round-robin arbitration,
// an optional bounded burst lock, address range checking and a read
// response pipeline.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-low reset
//   req_valid   in   [NUM_REQ]      access request per requester
//   req_ready   out  [NUM_REQ]      one-hot grant; transfer on valid&ready
//   req_we      in   [NUM_REQ]      1 = write, 0 = read
//   req_lock    in   [NUM_REQ]      ask to keep the grant next cycle
//   req_addr    in   [NUM_REQ*32]   byte addresses, requester i at [32i+:32]
//   req_wdata   in   [NUM_REQ*32]   write data, same packing
//   rsp_valid   out  [NUM_REQ]      one-cycle read response pulse
//   rsp_data    out  [32]           read data shared by all requesters
//   rsp_err     out                 response belongs to an out-of-range read
//   err_sticky  out                 any out-of-range access since reset
//   bram_en     out                 BRAM enable
//   bram_addr   out  [32]           BRAM byte address (forwarded unchanged)
//   bram_wreq   out  [4]            BRAM byte write request
//   bram_wdata  out  [32]           BRAM write data
//   R_data      in   [32]           BRAM registered read data
// ---------------------------------------------------------------------------
module bram_arbiter
    import clipq_bram_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int DEPTH    = BRAM_DEPTH,
    parameter int MAX_LOCK = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      err_sticky,
    output logic                      bram_en,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [3:0]                bram_wreq,
    output logic [DATA_W-1:0]         bram_wdata,
    input  logic [DATA_W-1:0]         R_data
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_LOCK_C = CW'(MAX_LOCK);
    localparam logic [PW-1:0] PTR_RESET  = PW'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // Unpack the flat request buses
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]      rr_ptr_reg,      rr_ptr_next;
    logic               lock_active_reg, lock_active_next;
    logic [PW-1:0]      lock_owner_reg,  lock_owner_next;
    logic [CW-1:0]      lock_cnt_reg,    lock_cnt_next;
    logic [NUM_REQ-1:0] rsp_valid_reg,   rsp_valid_next;
    logic               rsp_err_reg,     rsp_err_next;
    logic               err_sticky_reg,  err_sticky_next;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] owner_onehot;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;
    logic               lock_hold;
    logic               sel_in_range;
    acc_kind_e          acc_kind;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (rr_grant)
    );

    // The owner keeps the port only while it still requests and has not
    // used up its burst budget; otherwise plain round-robin decides in the
    // same cycle. Once the budget is spent the pointer already equals the
    // owner, so round-robin naturally restarts from owner+1.
    assign lock_hold = lock_active_reg
                    && (lock_cnt_reg < MAX_LOCK_C)
                    && req_valid[lock_owner_reg];

    always_comb begin
        owner_onehot                 = '0;
        owner_onehot[lock_owner_reg] = 1'b1;
    end

    // Nothing is accepted while reset is held.
    assign grant     = !rst      ? '0
                     : lock_hold ? owner_onehot
                     :             rr_grant;
    assign grant_any = |grant;

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                grant_idx = PW'(k);
            end
        end
    end

    // Low two address bits are ignored by design: byte offsets within a
    // word select the same word and raise no alignment error.
    assign sel_in_range = word_in_range(addr_arr[grant_idx][ADDR_W-1:2], DEPTH);

    always_comb begin
        acc_kind = ACC_IDLE;
        if (grant_any) begin
            if (!sel_in_range) begin
                acc_kind = ACC_REJECT;
            end else if (req_we[grant_idx]) begin
                acc_kind = ACC_WRITE;
            end else begin
                acc_kind = ACC_READ;
            end
        end
    end

    // ------------------------------------------------------------------
    // BRAM pins and requester handshake
    // ------------------------------------------------------------------
    assign req_ready  = grant;
    assign bram_en    = (acc_kind == ACC_READ) || (acc_kind == ACC_WRITE);
    assign bram_wreq  = (acc_kind == ACC_WRITE) ? WREQ_FULL : WREQ_NONE;
    assign bram_addr  = addr_arr[grant_idx];
    assign bram_wdata = wdata_arr[grant_idx];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_next      = rr_ptr_reg;
        lock_active_next = lock_active_reg;
        lock_owner_next  = lock_owner_reg;
        lock_cnt_next    = lock_cnt_reg;

        if (grant_any) begin
            rr_ptr_next = grant_idx;
            if (req_lock[grant_idx]) begin
                if (lock_hold) begin
                    lock_cnt_next = lock_cnt_reg + CW'(1);
                end else begin
                    // Fresh lock: either no lock was active, the owner
                    // dropped out, or the budget forced a re-arbitration.
                    lock_active_next = 1'b1;
                    lock_owner_next  = grant_idx;
                    lock_cnt_next    = CW'(1);
                end
            end else begin
                lock_active_next = 1'b0;
                lock_owner_next  = '0;
                lock_cnt_next    = '0;
            end
        end else begin
            lock_active_next = 1'b0;
            lock_owner_next  = '0;
            lock_cnt_next    = '0;
        end
    end

    // Every accepted read answers one cycle later, out-of-range ones with
    // an error flag and zero data; writes never answer.
    always_comb begin
        rsp_valid_next  = grant & ~req_we;
        rsp_err_next    = (acc_kind == ACC_REJECT) && !req_we[grant_idx];
        err_sticky_next = err_sticky_reg || (acc_kind == ACC_REJECT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg      <= PTR_RESET;
            lock_active_reg <= 1'b0;
            lock_owner_reg  <= '0;
            lock_cnt_reg    <= '0;
            rsp_valid_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            err_sticky_reg  <= 1'b0;
        end else begin
            rr_ptr_reg      <= rr_ptr_next;
            lock_active_reg <= lock_active_next;
            lock_owner_reg  <= lock_owner_next;
            lock_cnt_reg    <= lock_cnt_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_err_reg     <= rsp_err_next;
            err_sticky_reg  <= err_sticky_next;
        end
    end

    // ------------------------------------------------------------------
    // Response outputs
    // ------------------------------------------------------------------
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_err    = rsp_err_reg;
    assign rsp_data   = rsp_err_reg ? '0 : R_data;
    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
// Directed testbench for bram_arbiter with a small behavioural BRAM.
// Unwritten BRAM words read back as 0x1000_0000 | word_index[9:0].
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

    logic         clk;
    logic         rst;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [2:0]   req_we;
    logic [2:0]   req_lock;
    logic [95:0]  req_addr;
    logic [95:0]  req_wdata;
    logic [2:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         err_sticky;
    logic         bram_en;
    logic [31:0]  bram_addr;
    logic [3:0]   bram_wreq;
    logic [31:0]  bram_wdata;
    logic [31:0]  R_data;

    int tests_run    = 0;
    int tests_failed = 0;

    bram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .err_sticky (err_sticky),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_wreq  (bram_wreq),
        .bram_wdata (bram_wdata),
        .R_data     (R_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port BRAM with registered read.
    logic [31:0]   mem [0:1023];
    logic [1023:0] written = '0;

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_wreq == 4'b1111) begin
                mem[bram_addr[11:2]]     <= bram_wdata;
                written[bram_addr[11:2]] <= 1'b1;
            end else begin
                R_data <= written[bram_addr[11:2]] ? mem[bram_addr[11:2]]
                                                   : (32'h1000_0000 | {22'd0, bram_addr[11:2]});
            end
        end
    end

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic lock,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_lock[i]           = lock;
        req_addr[32*i +: 32]  = addr;
        req_wdata[32*i +: 32] = wdata;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_reqs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want %b", rsp_valid, 3'b000); end
        tests_run++;
        if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        tests_run++;
        if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_err_sticky: got %b want 0", err_sticky); end
        tests_run++;
        if (bram_en !== 1'b0) begin tests_failed++; $display("FAIL reset_bram_en: got %b want 0", bram_en); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b001) begin tests_failed++; $display("FAIL reset_first_grant: got %b want %b", req_ready, 3'b001); end
        @(negedge clk);
        clear_reqs();
        repeat (2) @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_read();
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        #1;
        tests_run++;
        if (req_ready !== 3'b001) begin tests_failed++; $display("FAIL wr_ready: got %b want %b", req_ready, 3'b001); end
        tests_run++;
        if (bram_en !== 1'b1 || bram_wreq !== 4'b1111) begin tests_failed++; $display("FAIL wr_pins: en=%b wreq=%b want en=1 wreq=1111", bram_en, bram_wreq); end
        tests_run++;
        if (bram_addr !== 32'h10 || bram_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wr_addr_data: addr=%h data=%h want 00000010 deadbeef", bram_addr, bram_wdata); end

        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b010 || bram_en !== 1'b1 || bram_wreq !== 4'b0000) begin tests_failed++; $display("FAIL rd_grant: ready=%b en=%b wreq=%b want 010 1 0000", req_ready, bram_en, bram_wreq); end
        tests_run++;
        if (rsp_valid !== 3'b000) begin tests_failed++; $display("FAIL write_no_rsp: got %b want 000", rsp_valid); end

        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 3'b010 || rsp_data !== 32'hDEADBEEF || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL raw_rsp: valid=%b data=%h err=%b want 010 deadbeef 0", rsp_valid, rsp_data, rsp_err); end
        tests_run++;
        if (bram_en !== 1'b0 || req_ready !== 3'b000) begin tests_failed++; $display("FAIL idle_pins: en=%b ready=%b want 0 000", bram_en, req_ready); end

        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 32'h13, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b010 || bram_addr !== 32'h13) begin tests_failed++; $display("FAIL unaligned_addr: ready=%b addr=%h want 010 00000013", req_ready, bram_addr); end

        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 3'b010 || rsp_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL unaligned_rsp: valid=%b data=%h want 010 deadbeef", rsp_valid, rsp_data); end
        repeat (2) @(negedge clk);
        $display("[TB] test_write_read done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        logic [31:0] exp_data [3];
        logic [2:0]  exp_ready;
        logic [2:0]  exp_rsp;
        int          prev;
        exp_data[0] = 32'hDEADBEEF;
        exp_data[1] = 32'h1000_0008;
        exp_data[2] = 32'h1000_000C;

        // Serve requester 2 first so the pointer is 2 and 0 leads next.
        @(negedge clk);
        set_req(2, 1'b0, 1'b0, 32'h30, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b100) begin tests_failed++; $display("FAIL rr_prime: got %b want 100", req_ready); end

        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            clear_reqs();
            set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
            set_req(1, 1'b0, 1'b0, 32'h20, 32'h0);
            set_req(2, 1'b0, 1'b0, 32'h30, 32'h0);
            #1;
            exp_ready = 3'b001 << (c % 3);
            prev      = (c == 0) ? 2 : ((c - 1) % 3);
            exp_rsp   = 3'b001 << prev;
            tests_run++;
            if (req_ready !== exp_ready) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, exp_ready); end
            tests_run++;
            if (rsp_valid !== exp_rsp || rsp_data !== exp_data[prev]) begin tests_failed++; $display("FAIL rr_rsp[%0d]: valid=%b data=%h want %b %h", c, rsp_valid, rsp_data, exp_rsp, exp_data[prev]); end
        end

        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 3'b100 || rsp_data !== 32'h1000_000C) begin tests_failed++; $display("FAIL rr_last_rsp: valid=%b data=%h want 100 1000000c", rsp_valid, rsp_data); end
        repeat (2) @(negedge clk);
        $display("[TB] test_round_robin done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_lock();
        logic [2:0] exp_ready;
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 32'h20, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b010) begin tests_failed++; $display("FAIL lock_enter: got %b want 010", req_ready); end

        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            clear_reqs();
            set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
            set_req(1, 1'b0, 1'b1, 32'h20, 32'h0);
            set_req(2, 1'b0, 1'b0, 32'h30, 32'h0);
            #1;
            exp_ready = (c <= 15) ? 3'b010 : ((c == 16) ? 3'b100 : 3'b001);
            tests_run++;
            if (req_ready !== exp_ready) begin tests_failed++; $display("FAIL lock_grant[%0d]: got %b want %b", c, req_ready, exp_ready); end
        end
        @(negedge clk);
        clear_reqs();
        repeat (2) @(negedge clk);
        $display("[TB] test_lock done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_out_of_range();
        @(negedge clk);
        #1;
        tests_run++;
        if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL oor_pre_sticky: got %b want 0", err_sticky); end

        @(negedge clk);
        set_req(2, 1'b0, 1'b0, 32'h0003_A984, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b100 || bram_en !== 1'b0) begin tests_failed++; $display("FAIL oor_rd_pins: ready=%b en=%b want 100 0", req_ready, bram_en); end

        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 32'h0003_A984, 32'hCAFEF00D);
        #1;
        tests_run++;
        if (rsp_valid !== 3'b100 || rsp_data !== 32'h0 || rsp_err !== 1'b1) begin tests_failed++; $display("FAIL oor_rsp: valid=%b data=%h err=%b want 100 00000000 1", rsp_valid, rsp_data, rsp_err); end
        tests_run++;
        if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL oor_sticky_set: got %b want 1", err_sticky); end
        tests_run++;
        if (req_ready !== 3'b001 || bram_en !== 1'b0 || bram_wreq !== 4'b0000) begin tests_failed++; $display("FAIL oor_wr_pins: ready=%b en=%b wreq=%b want 001 0 0000", req_ready, bram_en, bram_wreq); end

        // Last valid word (index DEPTH-1) is in range.
        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b0, 1'b0, 32'h0003_A980, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b010 || bram_en !== 1'b1) begin tests_failed++; $display("FAIL top_word_in_range: ready=%b en=%b want 010 1", req_ready, bram_en); end
        tests_run++;
        if (rsp_valid !== 3'b000) begin tests_failed++; $display("FAIL oor_wr_no_rsp: got %b want 000", rsp_valid); end

        // Word that the dropped write would have aliased onto in the model.
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b0, 1'b0, 32'h0000_0984, 32'h0);
        #1;
        tests_run++;
        if (rsp_valid !== 3'b010 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL top_word_rsp: valid=%b err=%b want 010 0", rsp_valid, rsp_err); end

        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 3'b001 || rsp_data !== 32'h1000_0261) begin tests_failed++; $display("FAIL oor_wr_dropped: valid=%b data=%h want 001 10000261", rsp_valid, rsp_data); end

        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL oor_sticky_hold: got %b want 1", err_sticky); end
        $display("[TB] test_out_of_range done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midflight();
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b001) begin tests_failed++; $display("FAIL mid_grant: got %b want 001", req_ready); end

        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 3'b001) begin tests_failed++; $display("FAIL mid_pending: got %b want 001", rsp_valid); end
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0BAD0BAD);
        #1;
        tests_run++;
        if (rsp_valid !== 3'b000 || rsp_err !== 1'b0 || err_sticky !== 1'b0) begin tests_failed++; $display("FAIL mid_async_clear: valid=%b err=%b sticky=%b want 000 0 0", rsp_valid, rsp_err, err_sticky); end
        tests_run++;
        if (bram_en !== 1'b0 || bram_wreq !== 4'b0000 || req_ready !== 3'b000) begin tests_failed++; $display("FAIL mid_gated: en=%b wreq=%b ready=%b want 0 0000 000", bram_en, bram_wreq, req_ready); end

        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 3'b000) begin tests_failed++; $display("FAIL mid_held_rsp: got %b want 000", rsp_valid); end

        @(negedge clk);
        rst = 1'b1;
        clear_reqs();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b001) begin tests_failed++; $display("FAIL mid_ptr_restart: got %b want 001", req_ready); end

        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 3'b001 || rsp_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL mid_no_write: valid=%b data=%h want 001 deadbeef", rsp_valid, rsp_data); end
        repeat (2) @(negedge clk);
        $display("[TB] test_reset_midflight done");
    endtask

    initial begin
        rst = 1'b0;
        clear_reqs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock();
        test_out_of_range();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single-port accelerator scratch BRAM (one 32-bit access per clock, 1-cycle registered read) between NUM_REQ requesters, e.g. feature loader, weight loader and output writer.
- Performs round-robin arbitration with an optional bounded lock for bursts.
- Drives the BRAM en/addr/W_req/W_data pins and routes read data back to the requester whose read was granted.
- Rejects out-of-range addresses.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DEPTH, 60001, BRAM depth in 32-bit words; valid word index 0..DEPTH-1
MAX_LOCK, 16, maximum consecutive grants to one locked requester before forced release

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester access request
req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid&ready
req_we  in  NUM_REQ  1=write, 0=read
req_lock  in  NUM_REQ  requests retention of the grant for the next cycle
req_addr  in  NUM_REQ*32  byte addresses, requester i at bits [32i+31:32i]
req_wdata  in  NUM_REQ*32  write data, same packing
rsp_valid  out  NUM_REQ  one-cycle pulse: read data for requester i is on rsp_data
rsp_data  out  32  read data, shared by all requesters
rsp_err  out  1  qualifies rsp_valid: the read was out of range
err_sticky  out  1  set by any out-of-range access; cleared only by reset
bram_en  out  1  to BRAM en
bram_addr  out  32  to BRAM addr (byte address, forwarded unchanged)
bram_wreq  out  4  to BRAM W_req
bram_wdata  out  32  to BRAM W_data
R_data  in  32  from BRAM read data

Behaviour:
- Reset values: rsp_valid=0, rsp_err=0, err_sticky=0, lock counter=0, owner=none, rr pointer=NUM_REQ-1 (requester 0 has top priority first).
- Grant is combinational from req_valid and registered state. At most one requester is granted per cycle. req_ready is one-hot or zero.
- When no lock is active, priority is rr pointer+1, +2, ... modulo NUM_REQ. On each grant the rr pointer is set to the granted index.
- When a lock is active (owner O, counter < MAX_LOCK), O is granted if req_valid[O]=1, regardless of other requests.
  - If req_valid[O]=0, the lock drops immediately and normal round-robin applies in the same cycle.
- Lock entry: a granted requester with req_lock=1 becomes owner, counter=1.
- Each further locked grant increments the counter.
- When the counter reaches MAX_LOCK, the next cycle ignores the lock. Arbitration is round-robin from the owner+1, counter=0, and the owner must re-arbitrate to lock again.
- A grant with req_lock=0 clears ownership.
- Range check: word index = addr>>2. The access is in range iff index < DEPTH. Low two address bits are ignored (no alignment error).
- In-range grant drives these outputs combinationally:
  - bram_en=1
  - bram_addr=req_addr[g]
  - bram_wdata=req_wdata[g]
  - bram_wreq = 4'b1111 if write, 4'b0000 if read. Only full-word writes are supported.
- No grant: bram_en=0 and bram_wreq=0. bram_addr and bram_wdata hold the requester-0 mux value and are don't-care.
- Out-of-range grant: the request is still accepted (ready=1) but bram_en=0 and err_sticky is set next edge. A write is dropped.
- Read response:
  - Latency is exactly 1 cycle after the accepting edge.
  - rsp_valid[g]=1 for one cycle, and rsp_data=R_data.
  - For an out-of-range read, rsp_data=0 and rsp_err=1.
  - Writes produce no response.
  - Back-to-back reads give one response per cycle, in grant order.
- A read and a write in consecutive cycles from different requesters is legal. BRAM is single-port, so read-after-write to the same word in the next cycle returns the new data.
- Reset asserted mid-operation: all state clears asynchronously and any in-flight response is discarded (rsp_valid=0). No BRAM write occurs while rst=0 because bram_en is gated by reset.

Decomposition:
- Package clipq_bram_pkg holds ADDR_W=32, DATA_W=32, WREQ_FULL=4'b1111, WREQ_NONE=4'b0000 and the default BRAM_DEPTH=60001. The BRAM model and this block share the package.
- Sub-module rr_arbiter holds the parameterised N-way round-robin priority with pointer input: req vector plus pointer in, one-hot grant out. bram_arbiter adds the lock, range check, mux and response pipeline.

Test Plan:
- Reset, then req0 writes 0xDEADBEEF at addr 0x10 and req1 reads 0x10 the next cycle. Expect bram_wreq=1111 on the write cycle and rsp_valid=3'b010 with rsp_data=0xDEADBEEF one cycle after the read grant.
- All three requesters hold continuous reads with lock=0. Expect grants in the order 0,1,2,0,1,2 and one rsp_valid per cycle, each matching the granting requester delayed by 1.
- req1 asserts lock with continuous valid while req0 and req2 also request (MAX_LOCK=16). Expect req1 granted 16 consecutive cycles, then req2 granted, then req0.
- req2 reads addr 60001*4=0x3A984 (out of range). Expect bram_en=0, rsp_valid[2]=1 with rsp_data=0 and rsp_err=1, and err_sticky=1 until reset. An out-of-range write leaves BRAM contents unchanged.
- Read of addr 0x13 returns the word at index 4, identical to a read of 0x10.
- Assert rst low one cycle after a read grant. Expect no rsp_valid, all outputs at reset values, and the rr pointer restarted so req0 wins first after release.
